alu_nibble_sequencer: RTL and testbench

- Initiator/controller for the team's combinational 4-bit ALU slice (carry-lookahead slice with op/cin/less inputs and result/cout/set/overflow/zero outputs).
- Accepts a wide operation over a valid/ready request port.
- Drives the external slice one nibble per cycle, LSB first, chaining carry between nibbles.
- Accumulates result and flags, then presents them on a valid/ready response port.

---
 rtl/alu_nibble_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: drives an external combinational 4-bit ALU slice one
// nibble per cycle (LSB first), chaining carry between nibbles, and returns the
// assembled W-bit result with carry/overflow/zero flags over valid/ready.
module alu_nibble_sequencer #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_op,
   input  logic [4*NIBBLES-1:0] req_a,
   input  logic [4*NIBBLES-1:0] req_b,
   output logic [3:0]           slice_a,
   output logic [3:0]           slice_b,
   output logic                 slice_cin,
   output logic                 slice_less,
   output logic [2:0]           slice_op,
   input  logic [3:0]           slice_result,
   input  logic                 slice_cout,
   input  logic                 slice_set,
   input  logic                 slice_overflow,
   input  logic                 slice_zero,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [4*NIBBLES-1:0] res_data,
   output logic                 res_cout,
   output logic                 res_overflow,
   output logic                 res_zero
);

   localparam int unsigned    W      = 4 * NIBBLES;
   localparam int unsigned    IW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0]  LAST   = IW'(NIBBLES - 1);
   localparam logic [2:0]     OP_SLT = 3'b111;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_next;
   logic [IW-1:0] index;
   logic [2:0]    op_q;
   logic [W-1:0]  a_q, b_q;
   logic          carry_q;
   logic          zero_acc;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state decode plus handshake and slice drive; slice pins idle at 0 outside RUN
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      res_valid  = 1'b0;
      slice_a    = '0;
      slice_b    = '0;
      slice_cin  = 1'b0;
      slice_less = 1'b0;
      slice_op   = '0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = RUN;
         end
         RUN: begin
            slice_a   = a_q[4*index +: 4];
            slice_b   = b_q[4*index +: 4];
            slice_op  = op_q;
            slice_cin = (index == '0) ? op_q[2] : carry_q;
            if (index == LAST) state_next = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Request capture, per-nibble result/carry/zero accumulation, final flag capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         index        <= '0;
         op_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         carry_q      <= 1'b0;
         zero_acc     <= 1'b1;
         res_data     <= '0;
         res_cout     <= 1'b0;
         res_overflow <= 1'b0;
         res_zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q     <= req_op;
                  a_q      <= req_a;
                  b_q      <= req_b;
                  index    <= '0;
                  zero_acc <= 1'b1;
               end
            end
            RUN: begin
               if (op_q != OP_SLT) res_data[4*index +: 4] <= slice_result;
               carry_q  <= slice_cout;
               zero_acc <= zero_acc & slice_zero;
               index    <= index + 1'b1;
               if (index == LAST) begin
                  res_cout     <= slice_cout;
                  res_overflow <= slice_overflow;
                  // zero flag is registered here so it holds with res_data after the response
                  if (op_q == OP_SLT) begin
                     res_data <= W'(slice_set);
                     res_zero <= ~slice_set;
                  end else begin
                     res_zero <= zero_acc & slice_zero;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer: behavioural 4-bit slice model,
// vector table driven through a scoreboard, plus backpressure and mid-run reset.
module tb_alu_nibble_sequencer;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] data;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        chk_cin;
      logic [3:0]  cin;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [15:0] req_a, req_b;
   logic [3:0]  slice_a, slice_b, slice_result;
   logic        slice_cin, slice_less, slice_cout, slice_set, slice_overflow, slice_zero;
   logic [2:0]  slice_op;
   logic        res_valid, res_ready;
   logic [15:0] res_data;
   logic        res_cout, res_overflow, res_zero;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          accept_cyc = 0;
   int          cin_cnt = 0;
   logic [3:0]  cin_log = '0;
   logic        prev_valid = 1'b0;
   vec_t        sb[$];
   vec_t        tbl[11];

   alu_nibble_sequencer #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
      .slice_less(slice_less), .slice_op(slice_op),
      .slice_result(slice_result), .slice_cout(slice_cout), .slice_set(slice_set),
      .slice_overflow(slice_overflow), .slice_zero(slice_zero),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_cout(res_cout), .res_overflow(res_overflow), .res_zero(res_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural carry-lookahead slice: sum path shared by ADD/SUB/SLT
   logic [3:0] m_bb;
   logic [4:0] m_sum;
   logic       m_arith;
   always_comb begin
      m_arith = (slice_op == OP_ADD) || (slice_op == OP_SUB) || (slice_op == OP_SLT);
      m_bb    = slice_op[2] ? ~slice_b : slice_b;
      m_sum   = {1'b0, slice_a} + {1'b0, m_bb} + {4'b0, slice_cin};
      case (slice_op)
         OP_AND:         slice_result = slice_a & slice_b;
         OP_OR:          slice_result = slice_a | slice_b;
         OP_ADD, OP_SUB: slice_result = m_sum[3:0];
         OP_SLT:         slice_result = {3'b000, slice_less};
         default:        slice_result = slice_a ^ slice_b;
      endcase
      slice_cout     = m_arith ? m_sum[4] : 1'b0;
      slice_overflow = m_arith ? ((slice_a[3] == m_bb[3]) && (m_sum[3] != slice_a[3])) : 1'b0;
      slice_set      = m_sum[3];
      slice_zero     = (slice_result == 4'h0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] data, input logic cout, input logic ovf,
                               input logic zero, input logic chk_cin, input logic [3:0] cin);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.data = data;
      v.cout = cout; v.ovf = ovf; v.zero = zero; v.chk_cin = chk_cin; v.cin = cin;
      return v;
   endfunction

   // Present a request, wait (bounded) for acceptance, then scramble req_* to prove capture-only
   task automatic send(input vec_t v, input bit push);
      int n;
      @(negedge clk);
      req_op = v.op; req_a = v.a; req_b = v.b; req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         check("req_accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      if (push) sb.push_back(v);
      @(posedge clk);
      #1;
      accept_cyc = cyc;
      req_valid = 1'b0;
      req_op = 3'($urandom);
      req_a  = 16'($urandom);
      req_b  = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", sb.size(), 0);
   endtask

   // Monitor: logs slice_cin per RUN cycle, checks latency, pops scoreboard on each response handshake
   always @(negedge clk) begin
      vec_t e;
      if (rst) begin
         cin_cnt    = 0;
         prev_valid = 1'b0;
      end else begin
         if (!req_ready && !res_valid) begin
            if (cin_cnt < 4) cin_log[cin_cnt] = slice_cin;
            cin_cnt++;
         end
         if (res_valid && !prev_valid) check("latency", cyc - accept_cyc, 4);
         if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_response", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               check($sformatf("data op=%0b a=%h b=%h", e.op, e.a, e.b), res_data, e.data);
               check($sformatf("cout op=%0b a=%h b=%h", e.op, e.a, e.b), res_cout, e.cout);
               check($sformatf("ovf op=%0b a=%h b=%h", e.op, e.a, e.b), res_overflow, e.ovf);
               check($sformatf("zero op=%0b a=%h b=%h", e.op, e.a, e.b), res_zero, e.zero);
               if (e.chk_cin) check("cin_sequence", cin_log, e.cin);
            end
            cin_cnt = 0;
         end
         prev_valid = res_valid;
      end
   end

   initial begin
      int  n;
      bit  saw;
      // cin vectors list nibble 0 in bit 0
      tbl[0]  = mk(OP_ADD, 16'h00FF, 16'h0001, 16'h0100, 0, 0, 0, 1, 4'b0110);
      tbl[1]  = mk(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 0, 4'b0000);
      tbl[2]  = mk(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 0, 4'b0000);
      tbl[3]  = mk(OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1, 0, 1, 1, 4'b1111);
      tbl[4]  = mk(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 1, 4'b0000);
      tbl[5]  = mk(OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 0, 0, 0, 0, 4'b0000);
      tbl[6]  = mk(OP_SLT, 16'h0003, 16'h0007, 16'h0001, 0, 0, 0, 0, 4'b0000);
      tbl[7]  = mk(OP_SLT, 16'h0007, 16'h0003, 16'h0000, 1, 0, 1, 0, 4'b0000);
      tbl[8]  = mk(OP_SUB, 16'h1234, 16'h2345, 16'hEEEF, 0, 0, 0, 0, 4'b0000);
      tbl[9]  = mk(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 0, 4'b0000);
      tbl[10] = mk(3'b011, 16'h5A5A, 16'h0FF0, 16'h55AA, 0, 0, 0, 1, 4'b0000);

      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_res_flags", {res_cout, res_overflow, res_zero}, 0);
      check("rst_slice_outs", {slice_a, slice_b, slice_cin, slice_less, slice_op}, 0);
      #20;
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         send(tbl[i], 1'b1);
         drain();
      end

      // Backpressure: response must hold while req_* toggle and nothing is accepted
      res_ready = 1'b0;
      send(mk(OP_ADD, 16'h1111, 16'h2222, 16'h3333, 0, 0, 0, 0, 4'b0000), 1'b1);
      n = 0;
      while (!res_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_res_valid_seen", res_valid, 1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_data", res_data, 16'h3333);
         check("bp_hold_valid", res_valid, 1);
         check("bp_req_ready", req_ready, 0);
         req_valid = i[0];
         req_a = 16'($urandom);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_idle", req_ready, 1);
      check("bp_release_valid_low", res_valid, 0);
      drain();
      send(mk(OP_AND, 16'hFFFF, 16'h1234, 16'h1234, 0, 0, 0, 0, 4'b0000), 1'b1);
      drain();

      // Reset while RUN is at nibble index 2: abort with no response
      @(negedge clk);
      req_op = OP_ADD; req_a = 16'hAAAA; req_b = 16'h5555; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check("abort_run_idx2_slice_a", slice_a, 4'hA);
      rst = 1'b1;
      #1;
      check("abort_req_ready", req_ready, 1);
      check("abort_res_valid", res_valid, 0);
      check("abort_res_data", res_data, 0);
      check("abort_res_flags", {res_cout, res_overflow, res_zero}, 0);
      check("abort_slice_outs", {slice_a, slice_b, slice_cin, slice_less, slice_op}, 0);
      @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (res_valid) saw = 1'b1;
      end
      check("abort_no_response", saw, 0);
      send(mk(OP_ADD, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 0, 4'b0000), 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
